// File: rtl/fir_coef_loader.sv
`timescale 1ns/1ps
// fir_coef_loader
//   Streams FIR coefficient words into the write port (s1) of fir_memory.
//   Words are written to consecutive addresses from a commanded base, with
//   the address wrapping modulo 2^ADDR_W. While a load is in progress the
//   filter's adj input is held low so coefficient updates halt.
//
//   Optional feature, macro FIR_LOADER_VERIFY_EN: after the load, the words
//   are read back through the same port and their modulo sum is compared
//   with the sum of the accepted words; a mismatch sets the sticky err.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, base_addr, count   load command (count 0..2^ADDR_W)
//   s_valid, s_data, s_ready  coefficient stream
//   fir_memory_s1_*           memory port (registered outputs, readdata in)
//   adj                       filter update enable (low while busy)
//   busy, done, err           status: in progress, completion pulse, verify fail
module fir_coef_loader #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic [ADDR_W-1:0]   fir_memory_s1_address,
    output logic                fir_memory_s1_chipselect,
    output logic                fir_memory_s1_clken,
    output logic                fir_memory_s1_write,
    output logic [DATA_W-1:0]   fir_memory_s1_writedata,
    output logic [DATA_W/8-1:0] fir_memory_s1_byteenable,
    input  logic [DATA_W-1:0]   fir_memory_s1_readdata,
    output logic                adj,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   waddr;    // next address to access
    logic [ADDR_W:0]     remain;   // words still to accept

`ifdef FIR_LOADER_VERIFY_EN
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     iss_left; // reads still to issue
    logic [ADDR_W:0]     rd_left;  // read results still to collect
    logic                rd_pend;  // readdata of last cycle's read is valid now
    logic [DATA_W-1:0]   wr_sum;
    logic [DATA_W-1:0]   rd_sum;
    logic                err_q;

    assign err = err_q;
`else
    logic unused_rd;

    assign err       = 1'b0;
    assign unused_rd = ^fir_memory_s1_readdata;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                    <= IDLE;
            waddr                    <= '0;
            remain                   <= '0;
            s_ready                  <= 1'b0;
            fir_memory_s1_address    <= '0;
            fir_memory_s1_chipselect <= 1'b0;
            fir_memory_s1_clken      <= 1'b0;
            fir_memory_s1_write      <= 1'b0;
            fir_memory_s1_writedata  <= '0;
            fir_memory_s1_byteenable <= '0;
            adj                      <= 1'b1;
            busy                     <= 1'b0;
            done                     <= 1'b0;
`ifdef FIR_LOADER_VERIFY_EN
            base_q   <= '0;
            cnt_q    <= '0;
            iss_left <= '0;
            rd_left  <= '0;
            rd_pend  <= 1'b0;
            wr_sum   <= '0;
            rd_sum   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            // Access strobes are single-cycle; re-asserted per access below.
            fir_memory_s1_chipselect <= 1'b0;
            fir_memory_s1_clken      <= 1'b0;
            fir_memory_s1_write      <= 1'b0;
            fir_memory_s1_byteenable <= '0;
            done                     <= 1'b0;
`ifdef FIR_LOADER_VERIFY_EN
            rd_pend <= fir_memory_s1_chipselect & ~fir_memory_s1_write;
`endif
            case (state)
                IDLE: begin
                    // busy still high here means this is the done-pulse
                    // cycle: release the filter now, accept commands next.
                    if (busy) begin
                        busy <= 1'b0;
                        adj  <= 1'b1;
                    end else if (start) begin
                        busy   <= 1'b1;
                        adj    <= 1'b0;
                        waddr  <= base_addr;
                        remain <= count;
`ifdef FIR_LOADER_VERIFY_EN
                        base_q <= base_addr;
                        cnt_q  <= count;
                        wr_sum <= '0;
                        err_q  <= 1'b0;
`endif
                        if (count == '0) begin
                            state <= DONE;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // s_ready is high for the whole of LOAD
                    if (s_valid) begin
                        fir_memory_s1_address    <= waddr;
                        fir_memory_s1_chipselect <= 1'b1;
                        fir_memory_s1_clken      <= 1'b1;
                        fir_memory_s1_write      <= 1'b1;
                        fir_memory_s1_writedata  <= s_data;
                        fir_memory_s1_byteenable <= '1;
                        waddr  <= waddr + 1'b1;
                        remain <= remain - 1'b1;
`ifdef FIR_LOADER_VERIFY_EN
                        wr_sum <= wr_sum + s_data;
`endif
                        if (remain == 1) begin
                            s_ready <= 1'b0;
`ifdef FIR_LOADER_VERIFY_EN
                            // The last write occupies the port next cycle;
                            // reads start the cycle after that.
                            state    <= VERIFY;
                            waddr    <= base_q;
                            iss_left <= cnt_q;
                            rd_left  <= cnt_q;
                            rd_sum   <= '0;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef FIR_LOADER_VERIFY_EN
                VERIFY: begin
                    if (iss_left != '0) begin
                        fir_memory_s1_address    <= waddr;
                        fir_memory_s1_chipselect <= 1'b1;
                        fir_memory_s1_clken      <= 1'b1;
                        waddr    <= waddr + 1'b1;
                        iss_left <= iss_left - 1'b1;
                    end
                    if (rd_pend) begin
                        rd_sum  <= rd_sum + fir_memory_s1_readdata;
                        rd_left <= rd_left - 1'b1;
                        if (rd_left == 1) begin
                            err_q <= (rd_sum + fir_memory_s1_readdata) != wr_sum;
                            state <= DONE;
                        end
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
`timescale 1ns/1ps
// Self-checking bench for fir_coef_loader: randomized stream stimulus, a
// cycle-accurate behavioural model checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_fir_coef_loader;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;
`ifdef FIR_LOADER_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [AW-1:0] addr;
    logic          cs, clken, wr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] be;
    logic [DW-1:0] readdata = '0;
    logic          adj, busy, done, err;

    always #5 clk = ~clk;

    fir_coef_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fir_memory_s1_address(addr), .fir_memory_s1_chipselect(cs),
        .fir_memory_s1_clken(clken), .fir_memory_s1_write(wr),
        .fir_memory_s1_writedata(wdata), .fir_memory_s1_byteenable(be),
        .fir_memory_s1_readdata(readdata),
        .adj(adj), .busy(busy), .done(done), .err(err)
    );

    // Memory: 1-cycle read latency; corrupt_addr flips bit 0 on readback.
    logic [DW-1:0] mem [0:DEPTH-1];
    int corrupt_addr = -1;
    always @(posedge clk) begin
        if (cs && clken) begin
            if (wr) mem[addr] <= wdata;
            else    readdata  <= mem[addr] ^ ((int'(addr) == corrupt_addr) ? 32'h1 : 32'h0);
        end
    end

    int total = 0;
    int bad = 0;
    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Behavioural model state (predicts the current cycle's outputs)
    int cyc = 0;
    bit m_busy = 0, m_load = 0, m_wr = 0, m_err = 0, m_err_val = 0, m_hit = 0;
    int m_left = 0, m_n = 0, m_addr = 0, m_wa = 0, m_done = -1, m_err_at = -1, m_vfy_lo = -1;
    logic [DW-1:0] m_wd = '0;
    bit hs, n_wr, in_vfy;
    // Logs observed from the DUT (grow only)
    int wr_log[$];
    logic [DW-1:0] wd_log[$];
    int done_cnt = 0, done_cyc = -1, busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_out", {addr, wdata, be, s_ready, cs, clken, wr, busy, done, err, adj}, 64'd1);
            m_busy = 0; m_load = 0; m_wr = 0; m_err = 0; m_left = 0;
            m_done = -1; m_err_at = -1; m_vfy_lo = -1;
        end else begin
            in_vfy = VFY && cyc >= m_vfy_lo && cyc < m_done;
            chk("s_ready", s_ready, m_load);
            chk("write", wr, m_wr);
            if (m_wr) begin
                chk("wr_addr", addr, m_wa);
                chk("wr_data", wdata, m_wd);
                chk("byteen", be, 4'hF);
            end else begin
                chk("byteen_idle", be, 0);
            end
            if (!in_vfy) begin
                chk("chipsel", cs, m_wr);
                chk("clken", clken, m_wr);
            end
            chk("done", done, cyc == m_done);
            chk("busy", busy, m_busy);
            chk("adj", adj, !m_busy);
            chk("err", err, m_err);
            if (wr) begin wr_log.push_back(int'(addr)); wd_log.push_back(wdata); end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) busy_cnt++;
            // advance the model over the coming edge
            hs = m_load && s_valid;
            n_wr = 0;
            if (hs) begin
                n_wr = 1;
                m_wa = m_addr;
                m_wd = s_data;
                if (m_addr == corrupt_addr) m_hit = 1;
                m_addr = (m_addr + 1) % DEPTH;
                m_left--;
                if (m_left == 0) begin
                    m_load = 0;
                    m_done = cyc + 2 + (VFY ? m_n + 2 : 0);
                    m_vfy_lo = cyc + 2;
                    if (VFY) begin m_err_at = m_done - 1; m_err_val = m_hit; end
                end
            end
            if (start && !m_busy) begin
                m_busy = 1;
                m_err = 0;
                m_n = int'(count);
                m_hit = 0;
                if (count == 0) m_done = cyc + 2;
                else begin m_load = 1; m_left = int'(count); m_addr = int'(base_addr); end
            end else if (cyc == m_done) begin
                m_busy = 0;
            end
            if (cyc + 1 == m_err_at) m_err = m_err_val;
            m_wr = n_wr;
        end
        cyc++;
    end

    logic [DW-1:0] wq[$];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic cmd(input int b, input int n);
        start = 1'b1; base_addr = AW'(b); count = (AW+1)'(n);
        step();
        start = 1'b0;
    endtask

    // Send n words (from wq if loaded, else random); pct = valid probability.
    task automatic stream(input int n, input int pct);
        int sent = 0, guard = 0;
        bit h;
        while (sent < n && guard < 2000) begin
            s_valid = ($urandom_range(99) < pct);
            s_data = (wq.size() > 0) ? wq[0] : $urandom;
            @(negedge clk);
            h = s_valid && s_ready;
            step();
            if (h) begin sent++; if (wq.size() > 0) void'(wq.pop_front()); end
            guard++;
        end
        s_valid = 1'b0;
        chk("stream_words_accepted", sent, n);
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 400) begin step(); k++; end
        chk("done_timeout", done_cnt > d0, 1);
        step(); step();
    endtask

    int t0, w0, d0, b0;

    initial begin
        // reset
        repeat (3) step();
        rst = 1'b1;
        step();

        // s_valid noise while idle consumes nothing
        w0 = wr_log.size();
        repeat (8) begin s_valid = $urandom; s_data = $urandom; step(); end
        s_valid = 1'b0;
        step();
        chk("idle_noise_no_write", wr_log.size(), w0);

        // nominal: base 0x10, words 1..4 back to back
        w0 = wr_log.size(); d0 = done_cnt;
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        t0 = cyc;
        cmd(16'h0010, 4);
        stream(4, 100);
        wait_done(d0);
        chk("nom_nwrites", wr_log.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("nom_addr", wr_log[w0+i], 16 + i);
            chk("nom_data", wd_log[w0+i], i + 1);
        end
        chk("nom_done_cnt", done_cnt - d0, 1);
        chk("nom_done_cyc", done_cyc - t0, VFY ? 12 : 6);

        // wrap with backpressure
        w0 = wr_log.size(); d0 = done_cnt;
        cmd(16'h7FFE, 3);
        stream(3, 50);
        wait_done(d0);
        chk("wrap_nwrites", wr_log.size() - w0, 3);
        chk("wrap_a0", wr_log[w0], 16'h7FFE);
        chk("wrap_a1", wr_log[w0+1], 16'h7FFF);
        chk("wrap_a2", wr_log[w0+2], 0);

        // zero count
        w0 = wr_log.size(); d0 = done_cnt; b0 = busy_cnt;
        t0 = cyc;
        cmd(16'h0123, 0);
        repeat (5) step();
        chk("zero_nwrites", wr_log.size() - w0, 0);
        chk("zero_done_cyc", done_cyc - t0, 2);
        chk("zero_done_cnt", done_cnt - d0, 1);
        chk("zero_busy_cycles", busy_cnt - b0, 2);

        // start while busy is dropped
        w0 = wr_log.size(); d0 = done_cnt;
        cmd(16'h0200, 6);
        fork
            stream(6, 60);
            begin
                repeat (3) @(posedge clk);
                #2 start = 1'b1; base_addr = 15'h0100; count = 16'd2;
                @(posedge clk);
                #2 start = 1'b0;
            end
        join
        wait_done(d0);
        chk("busy_start_nwrites", wr_log.size() - w0, 6);
        for (int i = 0; i < 6; i++) chk("busy_start_addr", wr_log[w0+i], 16'h0200 + i);
        chk("busy_start_done_cnt", done_cnt - d0, 1);

        // reset mid-load after 2 of 8 words
        cmd(16'h0300, 8);
        stream(2, 100);
        rst = 1'b0;
        d0 = done_cnt;
        step(); step();
        rst = 1'b1;
        repeat (15) step();
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_adj_high", adj, 1);
        chk("rst_not_busy", busy, 0);

        // randomized loads
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(24, 1);
            w0 = wr_log.size(); d0 = done_cnt;
            cmd($urandom_range(DEPTH - 1), n);
            stream(n, $urandom_range(100, 30));
            wait_done(d0);
            chk("rand_nwrites", wr_log.size() - w0, n);
        end

`ifdef FIR_LOADER_VERIFY_EN
        // verify, good memory
        d0 = done_cnt;
        corrupt_addr = -1;
        wq = '{32'hA5A5A5A5, 32'h1};
        cmd(16'h0040, 2);
        stream(2, 100);
        wait_done(d0);
        chk("vfy_ok_err", err, 0);
        // verify, one word corrupted on readback
        d0 = done_cnt;
        corrupt_addr = 16'h0041;
        wq = '{32'hA5A5A5A5, 32'h1};
        cmd(16'h0040, 2);
        stream(2, 100);
        wait_done(d0);
        chk("vfy_bad_err", err, 1);
        repeat (5) step();
        chk("vfy_err_sticky", err, 1);
        corrupt_addr = -1;
        cmd(16'h0050, 0);
        chk("vfy_err_cleared", err, 0);
        repeat (4) step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Writes FIR coefficient words into the write port (s1) of the dual-port `fir_memory`, whose read port (s2) feeds the mic filter. Coefficients arrive as a valid/ready stream from the control side and are written to consecutive addresses starting at a commanded base. While a load is in progress the block drives the filter's `adj` input low, so coefficient updates halt.

## Interface
- `ADDR_W`, default 15: memory address width.
- `DATA_W`, default 32: coefficient word width.

Ports:
- `clk`  in  1  system clock (filter clock domain, nom. 25 MHz)
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle load command; ignored while `busy`
- `base_addr`  in  ADDR_W  first write address, latched on `start`
- `count`  in  ADDR_W+1  words to write (0..2^ADDR_W), latched on `start`
- `s_valid`  in  1  coefficient word valid
- `s_data`  in  DATA_W  coefficient word
- `s_ready`  out  1  loader accepts word
- `fir_memory_s1_address`  out  ADDR_W  write/read address
- `fir_memory_s1_chipselect`  out  1  memory access strobe
- `fir_memory_s1_clken`  out  1  memory clock enable
- `fir_memory_s1_write`  out  1  write strobe
- `fir_memory_s1_writedata`  out  DATA_W  write data
- `fir_memory_s1_byteenable`  out  DATA_W/8  all ones during writes
- `fir_memory_s1_readdata`  in  DATA_W  read data, 1-cycle latency (used only with verify)
- `adj`  out  1  filter update enable: high in IDLE, low while `busy`
- `busy`  out  1  load or verify in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky verify mismatch; cleared on `start`

## Operation
- States: IDLE, LOAD, VERIFY (only with the macro), DONE.
- IDLE: `s_ready`=0. On `start`, latch `base_addr` and `count`, then go to LOAD. If `count`=0, go straight to DONE with no memory access.
- LOAD: `s_ready`=1. Each handshake (`s_valid`&`s_ready`) writes one word. Address increments modulo 2^ADDR_W, so 0x7FFF wraps to 0x0000. The remaining-word count decrements on each handshake. After the last handshake `s_ready` drops, and the state goes to VERIFY, or to DONE without the macro.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` pulses received while busy are dropped, with no queuing.
- `s_valid` seen outside LOAD is ignored, and no word is consumed.
- Reset value of every output: 0, except `adj`=1. `byteenable` is 0 outside writes.
- Reset asserted mid-load aborts the load immediately. Memory keeps any words already written, and no `done` is issued.

## Timing
- A handshake in cycle N produces the write in cycle N+1: `chipselect`=`clken`=`write`=1, with registered address, data and byteenable.
- Throughput is one word per cycle. Load latency from `start` to `done` is `count`+2 cycles with `s_valid` held high.
- `busy` and `adj` change the cycle after `start`. `busy` falls, and `adj` rises, the cycle after the `done` pulse.
- Read (verify) phase: read address issued in cycle t; `readdata` is sampled in cycle t+1. Reads are fully pipelined at one per cycle.

## Configuration
- `FIR_LOADER_VERIFY_EN` defined:
  - During LOAD, accumulate a 32-bit modulo sum of the accepted words.
  - VERIFY then reads back `count` words from `base_addr`, with the same wrap rule, and sums them.
  - After the last read returns, compare the two sums and set `err` on mismatch, then DONE.
  - Adds `count`+2 cycles to the load latency.
- Not defined:
  - No VERIFY state and no accumulator.
  - `err` is tied 0 and `fir_memory_s1_readdata` is unused.

## Test plan
- Nominal load: `start` with base=0x0010, count=4, words 1,2,3,4 streamed back to back. Writes go to 0x10..0x13 in consecutive cycles, `done` pulses once, and `adj` is low for the whole load.
- Wrap and backpressure: base=0x7FFE, count=3, with `s_valid` toggling. Writes go to 0x7FFE, 0x7FFF, 0x0000, with exactly one write per handshake and no write in idle cycles.
- Zero count: `start` with count=0. There is no write strobe, `done` pulses at cycle 2, and `busy` is high for 2 cycles.
- Start while busy: a second `start` (base=0x100) mid-load is ignored. All writes follow the first command.
- Reset mid-load: `rst` low after 2 of 8 words. Outputs return to reset values immediately, `adj`=1, and no `done` follows.
- Verify (macro on): load 0xA5A5A5A5, 0x1 with memory behaving correctly, giving `err`=0. Repeat with the model corrupting one word, giving `err`=1 and staying 1 until the next `start`.
